// File: rtl/load_store_unit.sv
// load_store_unit: word-port load/store initiator; sub-word stores use read-modify-write.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses return an error with no memory access.
`default_nettype none

module load_store_unit #(
  parameter int unsigned RD_LATENCY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [3:0] LAT = 4'(RD_LATENCY);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_we_q;

  logic        req_err_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;
  logic [31:0] load_d;
  logic [31:0] merge_d;

  assign req_ready  = (state_q == S_IDLE) && !reset;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;

  always_comb begin
    req_err_d = (req_size == 2'b11);
`ifdef MISALIGN_TRAP_EN
    if (req_size == 2'b01 && req_addr[0])
      req_err_d = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
      req_err_d = 1'b1;
`endif
  end

  // Lane extraction for loads and lane merge for sub-word stores, both from mem_rdata.
  always_comb begin
    byte_d = mem_rdata[{lane_q, 3'b000} +: 8];
    half_d = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_d = {{24{signed_q & byte_d[7]}}, byte_d};
      2'b01:   load_d = {{16{signed_q & half_d[15]}}, half_d};
      default: load_d = mem_rdata;
    endcase
    merge_d = mem_rdata;
    if (size_q == 2'b00)
      merge_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merge_d[{lane_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      wdata_q      <= 16'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_we_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            size_q     <= req_size;
            signed_q   <= req_signed;
            lane_q     <= req_addr[1:0];
            wdata_q    <= req_wdata[15:0];
            mem_addr_q <= {req_addr[31:2], 2'b00};
            if (req_err_d) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
              state_q      <= S_RESP;
            end else if (req_we && req_size == 2'b10) begin
              mem_wdata_q <= req_wdata;
              mem_we_q    <= 1'b1;
              state_q     <= S_WR;
            end else begin
              cnt_q   <= LAT;
              state_q <= S_RD;
            end
          end
        end
        S_RD: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (we_q) begin
            mem_wdata_q <= merge_d;
            mem_we_q    <= 1'b1;
            state_q     <= S_WR;
          end else begin
            resp_rdata_q <= load_d;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_WR: begin
          resp_rdata_q <= 32'd0;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: two LSU instances (RD_LATENCY 0 and 3), each with its own word memory,
// checked against an arithmetic reference model of loads, stores, errors and latency.
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        preload;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_valid  [2];
  logic        resp_ready [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic [31:0] mem_addr   [2];
  logic [31:0] mem_wdata  [2];
  logic        mem_we     [2];
  logic [31:0] mem_rdata  [2];

  logic [31:0] tb_mem  [2][16];
  logic [31:0] ref_mem [2][16];
  int          we_cnt  [2];
  logic [31:0] we_data [2];

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_rd;
  logic        last_err;
  int          last_lat;
  logic [31:0] last_wd;

  always #5 clk = ~clk;

  load_store_unit #(.RD_LATENCY(0)) u_dut0 (
    .clk(clk), .reset(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_we(mem_we[0]), .mem_rdata(mem_rdata[0])
  );

  load_store_unit #(.RD_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_we(mem_we[1]), .mem_rdata(mem_rdata[1])
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0: return 32'd3;
      1: return 32'd16;
      2: return 32'd20;
      3: return 32'd99;
      default: return 32'hA500_0000 + 32'(i) * 32'h0001_0203;
    endcase
  endfunction

  assign mem_rdata[0] = tb_mem[0][mem_addr[0][5:2]];
  assign mem_rdata[1] = tb_mem[1][mem_addr[1][5:2]];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (preload) begin
        for (int i = 0; i < 16; i++) tb_mem[d][i] <= init_word(i);
        we_cnt[d] <= 0;
      end else if (mem_we[d]) begin
        tb_mem[d][mem_addr[d][5:2]] <= mem_wdata[d];
        we_cnt[d]  <= we_cnt[d] + 1;
        we_data[d] <= mem_wdata[d];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference behaviour: plain shift/mask arithmetic on the reference memory image.
  task automatic model(input int d, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic err, output logic [31:0] rd, output logic [31:0] wd,
                       output int lat, output int nwe);
    int          idx;
    int          off;
    int          lrd;
    logic [31:0] w;
    logic [31:0] mask;
    logic [31:0] val;
    idx = int'(addr[5:2]);
    off = int'(addr[1:0]);
    lrd = (d == 0) ? 0 : 3;
    w   = ref_mem[d][idx];
    err = (size == 2'b11);
`ifdef MISALIGN_TRAP_EN
    if (size == 2'b01 && off % 2 != 0) err = 1'b1;
    if (size == 2'b10 && off != 0) err = 1'b1;
`endif
    if (size == 2'b01) off = (off / 2) * 2;
    if (size == 2'b10) off = 0;
    rd  = 32'd0;
    wd  = 32'd0;
    nwe = 0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat = 2 + lrd;
      if (size == 2'b00) begin
        val = (w >> (8 * off)) & 32'hFF;
        if (sgn && val >= 32'd128) val = val + 32'hFFFF_FF00;
      end else if (size == 2'b01) begin
        val = (w >> (8 * off)) & 32'hFFFF;
        if (sgn && val >= 32'd32768) val = val + 32'hFFFF_0000;
      end else begin
        val = w;
      end
      rd = val;
    end else begin
      lat  = (size == 2'b10) ? 2 : 3 + lrd;
      mask = (size == 2'b00) ? (32'hFF << (8 * off)) :
             (size == 2'b01) ? (32'hFFFF << (8 * off)) : 32'hFFFF_FFFF;
      wd   = (w & ~mask) | ((wdata << (8 * off)) & mask);
      ref_mem[d][idx] = wd;
      nwe  = 1;
    end
  endtask

  task automatic do_txn(input int d, input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    logic        e_err;
    logic [31:0] e_rd;
    logic [31:0] e_wd;
    int          e_lat;
    int          e_nwe;
    int          lat;
    int          we0;
    int          idx;
    idx = int'(addr[5:2]);
    model(d, we, size, sgn, addr, wdata, e_err, e_rd, e_wd, e_lat, e_nwe);
    @(negedge clk);
    chk("ready_idle", 32'(req_ready[d]), 32'd1);
    we0        = we_cnt[d];
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_addr     = $urandom();
    req_wdata    = $urandom();
    lat = 1;
    while (!resp_valid[d] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(e_lat));
    chk("rdata", resp_rdata[d], e_rd);
    chk("err", 32'(resp_err[d]), 32'(e_err));
    chk("ready_busy", 32'(req_ready[d]), 32'd0);
    last_rd  = resp_rdata[d];
    last_err = resp_err[d];
    last_lat = lat;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(resp_valid[d]), 32'd1);
      chk("hold_rdata", resp_rdata[d], e_rd);
      chk("hold_err", 32'(resp_err[d]), 32'(e_err));
      chk("hold_ready", 32'(req_ready[d]), 32'd0);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[d] = 1'b0;
    chk("valid_drop", 32'(resp_valid[d]), 32'd0);
    chk("ready_back", 32'(req_ready[d]), 32'd1);
    chk("we_pulses", 32'(we_cnt[d] - we0), 32'(e_nwe));
    last_wd = we_data[d];
    if (e_nwe != 0) chk("mem_wdata", we_data[d], e_wd);
    if (!e_err) chk("mem_addr", mem_addr[d], {addr[31:2], 2'b00});
    chk("mem_word", tb_mem[d][idx], ref_mem[d][idx]);
  endtask

  initial begin
    int we0;
    rst = 1'b1;
    preload = 1'b1;
    req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d]  = 1'b0;
      resp_ready[d] = 1'b0;
      for (int i = 0; i < 16; i++) ref_mem[d][i] = init_word(i);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 32'(req_ready[d]), 32'd0);
      chk("rst_valid", 32'(resp_valid[d]), 32'd0);
      chk("rst_err", 32'(resp_err[d]), 32'd0);
      chk("rst_rdata", resp_rdata[d], 32'd0);
      chk("rst_we", 32'(mem_we[d]), 32'd0);
      chk("rst_addr", mem_addr[d], 32'd0);
      chk("rst_wdata", mem_wdata[d], 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    preload = 1'b0;

    // Directed: word load, byte store RMW, signed/unsigned half with latency 3.
    do_txn(0, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 0);
    chk("t1_rdata", last_rd, 32'd16);
    chk("t1_lat", 32'(last_lat), 32'd2);
    do_txn(0, 1'b1, 2'b00, 1'b0, 32'h9, 32'hAB, 0);
    chk("t2_wdata", last_wd, 32'h0000_AB14);
    chk("t2_word2", tb_mem[0][2], 32'h0000_AB14);
    do_txn(1, 1'b1, 2'b10, 1'b0, 32'hC, 32'hFFFF_8000, 0);
    do_txn(1, 1'b0, 2'b01, 1'b1, 32'hC, 32'h0, 0);
    chk("t3_signed", last_rd, 32'hFFFF_8000);
    chk("t3_lat", 32'(last_lat), 32'd5);
    do_txn(1, 1'b0, 2'b01, 1'b0, 32'hC, 32'h0, 0);
    chk("t3_unsigned", last_rd, 32'h0000_8000);

    // Misaligned word load.
    do_txn(0, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 0);
`ifdef MISALIGN_TRAP_EN
    chk("t4_err", 32'(last_err), 32'd1);
    chk("t4_rdata", last_rd, 32'd0);
    chk("t4_lat", 32'(last_lat), 32'd1);
`else
    chk("t4_err", 32'(last_err), 32'd0);
    chk("t4_rdata", last_rd, 32'd16);
`endif

    // Reset while a sub-word store sits in RD: no write, no response.
    @(negedge clk);
    we0 = we_cnt[1];
    req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h1; req_wdata = 32'h5A;
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_ready_rst", 32'(req_ready[1]), 32'd0);
    chk("t5_we_rst", 32'(mem_we[1]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("t5_no_resp", 32'(resp_valid[1]), 32'd0);
    end
    chk("t5_ready", 32'(req_ready[1]), 32'd1);
    chk("t5_no_we", 32'(we_cnt[1] - we0), 32'd0);
    chk("t5_mem", tb_mem[1][0], ref_mem[1][0]);

    // Back-pressure on a load and on a reserved-size request.
    do_txn(0, 1'b0, 2'b00, 1'b1, 32'h3, 32'h0, 4);
    do_txn(0, 1'b1, 2'b11, 1'b0, 32'h8, 32'h1234, 4);
    chk("t6_err", 32'(last_err), 32'd1);
    chk("t6_rdata", last_rd, 32'd0);

    // Randomised traffic on both latencies.
    for (int n = 0; n < 60; n++) begin
      do_txn(n % 2, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom(), $urandom(), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
